sram_1rwnr_init: RTL and testbench

- Parametrised successor to the fixed 32x256 1RW+1R iCE40 SRAM wrapper.
- Generic width, depth and number of read-only ports, all on a single clock.
- Adds a hardware clear sequencer after reset, per-port read-valid strobes, and optional write-to-read bypass.
- Sits between the CPU/USB buffer logic and SB_RAM40_4K primitives, wherever a multi-read register file or buffer RAM is needed.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_1rwnr_init_if.sv | 33 +++
 rtl/sram_copy.sv | 54 +++++
 rtl/sram_1rwnr_init.sv | 138 +++++++++++++
 tb/tb_sram_1rwnr_init.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared constants, FSM state type and tile-geometry helper for the
// parametrised 1RW+NR SRAM built from 256x16 SB_RAM40_4K tiles.
package sram_pkg;

  localparam int TILE_W  = 16;
  localparam int TILE_AW = 8;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  // Each bank is one row of tiles covering 2**TILE_AW addresses.
  function automatic int nbanks(input int aw);
    return 1 << (aw - TILE_AW);
  endfunction

endpackage

// File: rtl/sram_1rwnr_init_if.sv
// Bus bundle for sram_1rwnr_init: port 0 read/write, NR read-only ports
// and the ready flag raised once the clear sequence has finished.
interface sram_1rwnr_init_if #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int NR = 1
);
  import sram_pkg::*;

  logic              ready;
  logic              p0_cs;
  logic              p0_we;
  logic [DW/8-1:0]   p0_wmask;
  logic [AW-1:0]     p0_addr;
  logic [DW-1:0]     p0_wdata;
  logic [DW-1:0]     p0_rdata;
  logic              p0_rvalid;
  logic [NR-1:0]     r_cs;
  logic [NR*AW-1:0]  r_addr;
  logic [NR*DW-1:0]  r_data;
  logic [NR-1:0]     r_valid;

  modport master (
    input  ready, p0_rdata, p0_rvalid, r_data, r_valid,
    output p0_cs, p0_we, p0_wmask, p0_addr, p0_wdata, r_cs, r_addr
  );

  modport slave (
    output ready, p0_rdata, p0_rvalid, r_data, r_valid,
    input  p0_cs, p0_we, p0_wmask, p0_addr, p0_wdata, r_cs, r_addr
  );

endinterface

// File: rtl/sram_copy.sv
// One full copy of the memory: nbanks rows of tiles, each row with its own
// read register, selected on output by the bank captured with the request.
module sram_copy
  import sram_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] wmask,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  localparam int NB    = nbanks(AW);
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int NBYTE = DW / 8;

  logic [BW-1:0]    wbank;
  logic [BW-1:0]    rbank;
  logic [BW-1:0]    sel_q;
  logic [NB*DW-1:0] bank_flat;

  assign wbank = BW'(waddr >> TILE_AW);
  assign rbank = BW'(raddr >> TILE_AW);

  always_ff @(posedge clk) begin
    if (re) sel_q <= rbank;
  end

  // Only the addressed row is clocked, mirroring the per-tile RCLKE/WCLKE.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DW-1:0] mem [2**TILE_AW];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we && wbank == BW'(b)) begin
        for (int i = 0; i < NBYTE; i++) begin
          if (wmask[i]) mem[waddr[TILE_AW-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      if (re && rbank == BW'(b)) rd_q <= mem[raddr[TILE_AW-1:0]];
    end

    assign bank_flat[b*DW +: DW] = rd_q;
  end

  assign rdata = bank_flat[int'(sel_q)*DW +: DW];

endmodule

// File: rtl/sram_1rwnr_init.sv
// 1RW + NR-read SRAM with post-reset clear to INIT_VAL and per-port valids.
// Define SRAM_RW_BYPASS_EN to forward same-cycle port-0 writes to readers.
module sram_1rwnr_init
  import sram_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            DW       = 32,
  parameter int            NR       = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic              clk,
  input logic              rst_n,
  sram_1rwnr_init_if.slave bus
);

  if (AW < 8 || AW > 10 || NR < 1 || NR > 4 || DW < TILE_W || (DW % TILE_W) != 0) begin : g_bad_param
    $error("sram_1rwnr_init: parameter out of range");
  end

  state_t              state;
  state_t              state_next;
  logic [AW-1:0]       cnt;
  logic                ready_q;
  logic                clr_we;
  logic                p0_wr;
  logic                p0_rd;
  logic [NR-1:0]       r_rd;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [DW-1:0]       wdata;
  logic [DW/8-1:0]     wmask;
  logic                p0_rvalid_q;
  logic [NR-1:0]       r_valid_q;
  logic [(NR+1)*DW-1:0] copy_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= (state == ST_READY);
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    clr_we     = 1'b0;
    case (state)
      ST_INIT: begin
        clr_we = 1'b1;
        if (cnt == '1) state_next = ST_READY;
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  // ready_q is low throughout INIT, so user and clear writes never overlap.
  assign p0_wr = bus.p0_cs & bus.p0_we & ready_q;
  assign p0_rd = bus.p0_cs & ~bus.p0_we & ready_q;
  assign r_rd  = bus.r_cs & {NR{ready_q}};
  assign we    = clr_we | p0_wr;
  assign waddr = clr_we ? cnt : bus.p0_addr;
  assign wdata = clr_we ? INIT_VAL : bus.p0_wdata;
  assign wmask = clr_we ? '1 : bus.p0_wmask;

  for (genvar c = 0; c <= NR; c++) begin : g_copy
    sram_copy #(.AW(AW), .DW(DW)) u_copy (
      .clk   (clk),
      .we    (we),
      .wmask (wmask),
      .waddr (waddr),
      .wdata (wdata),
      .re    ((c == 0) ? p0_rd : r_rd[(c == 0) ? 0 : c-1]),
      .raddr ((c == 0) ? bus.p0_addr : bus.r_addr[((c == 0) ? 0 : c-1)*AW +: AW]),
      .rdata (copy_rdata[c*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p0_rvalid_q <= 1'b0;
      r_valid_q   <= '0;
    end else begin
      p0_rvalid_q <= p0_rd;
      r_valid_q   <= r_rd;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p0_rdata  = p0_rvalid_q ? copy_rdata[0 +: DW] : '0;
  assign bus.r_valid   = r_valid_q;

`ifdef SRAM_RW_BYPASS_EN
  logic [NR-1:0]   hit_q;
  logic [DW-1:0]   byp_data_q;
  logic [DW/8-1:0] byp_mask_q;
  logic [DW-1:0]   byp_bits;

  // Only port-0 writes are captured; clear writes happen while ready_q=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q      <= '0;
      byp_data_q <= '0;
      byp_mask_q <= '0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        hit_q[k] <= p0_wr & r_rd[k] & (bus.r_addr[k*AW +: AW] == bus.p0_addr);
      end
      if (p0_wr) begin
        byp_data_q <= bus.p0_wdata;
        byp_mask_q <= bus.p0_wmask;
      end
    end
  end

  for (genvar i = 0; i < DW/8; i++) begin : g_mask
    assign byp_bits[i*8 +: 8] = {8{byp_mask_q[i]}};
  end

  for (genvar k = 0; k < NR; k++) begin : g_rport
    logic [DW-1:0] ram;
    logic [DW-1:0] merged;
    assign ram    = copy_rdata[(k+1)*DW +: DW];
    assign merged = hit_q[k] ? ((byp_data_q & byp_bits) | (ram & ~byp_bits)) : ram;
    assign bus.r_data[k*DW +: DW] = r_valid_q[k] ? merged : '0;
  end
`else
  for (genvar k = 0; k < NR; k++) begin : g_rport
    assign bus.r_data[k*DW +: DW] = r_valid_q[k] ? copy_rdata[(k+1)*DW +: DW] : '0;
  end
`endif

endmodule

// File: tb/tb_sram_1rwnr_init.sv
// Scoreboard bench for sram_1rwnr_init with AW=10, NR=2 and a nonzero
// INIT_VAL; expectations follow SRAM_RW_BYPASS_EN when it is defined.
module tb_sram_1rwnr_init;

  localparam int          AW   = 10;
  localparam int          DW   = 32;
  localparam int          NR   = 2;
  localparam logic [31:0] INIT = 32'hDEADBEEF;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_ready;
  exp_t q [NR+1][$];

  always #5 clk = ~clk;

  sram_1rwnr_init_if #(.AW(AW), .DW(DW), .NR(NR)) bus ();

  sram_1rwnr_init #(.AW(AW), .DW(DW), .NR(NR), .INIT_VAL(INIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every port is compared every cycle: either a due read or a silent, zeroed output.
  always @(negedge clk) begin
    for (int p = 0; p <= NR; p++) begin
      logic        v;
      logic [31:0] d;
      exp_t        e;
      v = (p == 0) ? bus.p0_rvalid : bus.r_valid[(p == 0) ? 0 : p-1];
      d = (p == 0) ? bus.p0_rdata  : bus.r_data[((p == 0) ? 0 : p-1)*DW +: DW];
      if (q[p].size() > 0 && q[p][0].due <= cyc) begin
        e = q[p].pop_front();
        check_output($sformatf("port%0d valid", p), {31'b0, v}, 32'd1);
        check_output($sformatf("port%0d data", p), d, e.data);
      end else begin
        check_output($sformatf("port%0d no-valid", p), {31'b0, v}, 32'd0);
        check_output($sformatf("port%0d idle-data", p), d, 32'd0);
      end
    end
  end

  task automatic apply_stimulus(input logic p0_cs, input logic p0_we, input logic [3:0] mask,
                                input logic [AW-1:0] p0_addr, input logic [31:0] wdata,
                                input logic [NR-1:0] r_cs, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1);
    bus.p0_cs    = p0_cs;
    bus.p0_we    = p0_we;
    bus.p0_wmask = mask;
    bus.p0_addr  = p0_addr;
    bus.p0_wdata = wdata;
    bus.r_cs     = r_cs;
    bus.r_addr   = {a1, a0};
    @(posedge clk);
    #1;
    bus.p0_cs = 1'b0;
    bus.r_cs  = '0;
  endtask

  task automatic expect_read(input int port, input logic [31:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 1;
    q[port].push_back(e);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    apply_stimulus(1'b1, 1'b1, m, a, d, '0, '0, '0);
  endtask

  task automatic read3(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    expect_read(0, e0);
    expect_read(1, e1);
    expect_read(2, e2);
    apply_stimulus(1'b1, 1'b0, 4'h0, a0, 32'h0, 2'b11, a1, a2);
  endtask

  // Counts edges after rst_n release until ready is seen, bounded by limit.
  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (!bus.ready && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    logic [31:0] coll_full;
    logic [31:0] coll_byte;
`ifdef SRAM_RW_BYPASS_EN
    coll_full = 32'h55555555;
    coll_byte = 32'hAAAAAA55;
`else
    coll_full = 32'hAAAAAAAA;
    coll_byte = 32'hAAAAAAAA;
`endif
    bus.p0_cs = 1'b0; bus.p0_we = 1'b0; bus.p0_wmask = '0; bus.p0_addr = '0;
    bus.p0_wdata = '0; bus.r_cs = '0; bus.r_addr = '0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset ready", {31'b0, bus.ready}, 32'd0);

    // Requests held throughout the clear must neither write nor respond.
    rst_n = 1'b1;
    bus.p0_cs = 1'b1; bus.p0_we = 1'b1; bus.p0_wmask = 4'hF;
    bus.p0_addr = 10'h3E8; bus.p0_wdata = 32'h12345678;
    bus.r_cs = 2'b11; bus.r_addr = {10'h3E8, 10'h3E8};
    wait_ready(2000, n_ready);
    bus.p0_cs = 1'b0; bus.r_cs = '0;
    check_output("ready latency", n_ready, 32'd1025);

    read3(10'h000, 10'h100, 10'h3FF, INIT, INIT, INIT);
    read3(10'h3FF, 10'h000, 10'h100, INIT, INIT, INIT);
    read3(10'h3E8, 10'h3E8, 10'h3E8, INIT, INIT, INIT);

    write_word(10'h005, 32'h11223344, 4'b0101);
    read3(10'h005, 10'h005, 10'h005, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);

    write_word(10'h0FF, 32'hA0A000FF, 4'hF);
    write_word(10'h100, 32'hB0B00100, 4'hF);
    write_word(10'h3FF, 32'hC0C003FF, 4'hF);
    read3(10'h0FF, 10'h100, 10'h3FF, 32'hA0A000FF, 32'hB0B00100, 32'hC0C003FF);
    read3(10'h100, 10'h3FF, 10'h0FF, 32'hB0B00100, 32'hC0C003FF, 32'hA0A000FF);

    write_word(10'h007, 32'hAAAAAAAA, 4'hF);
    expect_read(1, coll_full);
    expect_read(2, INIT);
    apply_stimulus(1'b1, 1'b1, 4'hF, 10'h007, 32'h55555555, 2'b11, 10'h007, 10'h006);
    read3(10'h007, 10'h007, 10'h007, 32'h55555555, 32'h55555555, 32'h55555555);

    write_word(10'h007, 32'hAAAAAAAA, 4'hF);
    expect_read(1, coll_byte);
    expect_read(2, coll_byte);
    apply_stimulus(1'b1, 1'b1, 4'h1, 10'h007, 32'h55555555, 2'b11, 10'h007, 10'h007);
    read3(10'h007, 10'h007, 10'h007, 32'hAAAAAA55, 32'hAAAAAA55, 32'hAAAAAA55);

    write_word(10'h005, 32'hFFFFFFFF, 4'h0);
    read3(10'h005, 10'h005, 10'h005, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44);

    // Reset from READY, then again at clear count 100, with reads held high.
    bus.r_cs = 2'b11; bus.r_addr = {10'h005, 10'h005};
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("mid-init ready", {31'b0, bus.ready}, 32'd0);
    rst_n = 1'b1;
    wait_ready(2000, n_ready);
    bus.r_cs = '0;
    check_output("re-init ready latency", n_ready, 32'd1025);

    read3(10'h005, 10'h007, 10'h3FF, INIT, INIT, INIT);
    read3(10'h0FF, 10'h100, 10'h000, INIT, INIT, INIT);

    repeat (3) @(posedge clk);
    #1;
    check_output("scoreboard drained", q[0].size() + q[1].size() + q[2].size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
